fifo_uart_tx: RTL
=================

# fifo_uart_tx

Downstream consumer of the byte FIFO: drains words from the FIFO read port and transmits each as an asynchronous serial frame (start, 8 data bits LSB-first, optional even parity, stop) on a single line. It issues exactly one FIFO read per frame, ignores FIFO status while a frame is in flight, and idles with the line high when the FIFO is empty. It sits between the FIFO's `op`/`empty`/`rd` side and the chip's serial output pin.

## Interface
- `DATA_W`, 8, word width; must match the FIFO data width.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_op` in `DATA_W`: FIFO read data; valid after the FIFO samples `fifo_rd` high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd` out 1: FIFO read strobe; registered, one-cycle pulse.
- `txd` out 1: serial output; idle high.
- `busy` out 1: high whenever the state is not IDLE.
- `tx_done` out 1: one-cycle pulse in the last cycle of each stop bit.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - If `fifo_empty` is 0 at the edge, go to REQ and set `fifo_rd` to 1.
  - Otherwise stay in IDLE with `txd` at 1.
- REQ, one cycle: `fifo_rd` is high. At the next edge, `fifo_rd` goes to 0 and the state goes to WAIT; the FIFO samples the read at this same edge.
- WAIT, one cycle: at the next edge, capture `fifo_op` into the shift register, load the bit counter with `CLKS_PER_BIT-1`, drive `txd` to 0, and go to START.
- START: hold `txd` at 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Output bit 0 first. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right.
  - A 3-bit index counts bits 0..`DATA_W-1`.
  - After the last bit, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: `txd` is the XOR of the captured word (even parity), held `CLKS_PER_BIT` cycles.
- STOP:
  - `txd` is 1 for `CLKS_PER_BIT` cycles. `tx_done` is high in the final cycle.
  - At that edge go to IDLE.
- The bit-period counter is a down-counter of width clog2(`CLKS_PER_BIT`), reloaded on each bit boundary; no accumulated drift.
- `fifo_empty` is sampled only in IDLE. Changes during REQ through STOP have no effect.
- At most one read per frame; `fifo_rd` is never high in two consecutive cycles.
- Reset at any time: the in-flight word is discarded and not re-read. After release, the block starts from IDLE.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `txd`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, shift register 0, counters 0.
- Latency: the edge that sees `fifo_empty`=0 in IDLE is E0.
  - `fifo_rd` is high between E0 and E1.
  - `txd` falls at E2.
- Frame length: (10+`PARITY_EN`)×`CLKS_PER_BIT` cycles of defined line state, from the `txd` fall to the end of the stop bit.
- Back-to-back: the stop bit ends and the state enters IDLE at the same edge.
  - If `fifo_empty`=0 at the following edge, the next start bit begins two edges after that.
  - Inter-frame idle-high gap is therefore exactly 3 cycles beyond the stop bit.
- `busy` rises with the REQ entry (E0) and falls at the edge entering IDLE.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, `PARITY_EN`=0: FIFO holds 0x11.
  - Exactly one `fifo_rd` pulse.
  - `txd` shows 0 (start), then 1,0,0,0,1,0,0,0, then 1 (stop), each bit 4 cycles.
  - `tx_done` pulses once; the FIFO ends empty.
- Burst: write 0x11, 0x06, 0x43, 0x14.
  - Exactly four `fifo_rd` pulses.
  - Four frames decode in that order.
  - 3-cycle idle gap between frames; `busy` stays high between frames except 1 cycle in IDLE.
- Parity: `PARITY_EN`=1, byte 0x43 (three ones): parity bit 1, frame length 11×`CLKS_PER_BIT`. Byte 0x06: parity bit 0.
- Empty hold: `fifo_empty`=1 for 100 cycles: `fifo_rd`=0, `txd`=1, `busy`=0 throughout.
- Reset mid-frame: assert `rst` during data bit 3 of 0x43.
  - `txd`=1 and `busy`=0 immediately, without waiting for a clock edge.
  - After release, the next FIFO word (not 0x43) is transmitted.
- Status ignored in flight: toggle `fifo_empty` every cycle during a frame.
  - No extra `fifo_rd`.
  - Frame bits unchanged.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains words from a FIFO read port and sends each one as an
//            asynchronous serial frame on txd: start bit, DATA_W data bits
//            LSB first, an optional even-parity bit, and a stop bit. Exactly
//            one FIFO read is issued per frame. FIFO status is only looked at
//            while idle.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous, active-high reset
//            fifo_op    - FIFO read data, valid the cycle after the read is taken
//            fifo_empty - FIFO empty flag, sampled only in IDLE
//            fifo_rd    - registered one-cycle FIFO read strobe
//            txd        - serial line, idles high
//            busy       - high whenever the FSM is not in IDLE
//            tx_done    - one-cycle pulse in the last cycle of each stop bit
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_op,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_req    = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_data   = 3'd4;
    localparam logic [2:0] c_st_parity = 3'd5;
    localparam logic [2:0] c_st_stop   = 3'd6;

    logic [2:0]         state_q,   state_d;
    logic               fifo_rd_q, fifo_rd_d;
    logic               txd_q,     txd_d;
    logic [DATA_W-1:0]  shreg_q,   shreg_d;
    logic               parity_q,  parity_d;
    logic [c_cnt_w-1:0] cnt_q,     cnt_d;
    logic [c_idx_w-1:0] idx_q,     idx_d;

    // Last cycle of the current bit period.
    logic w_bit_end;
    assign w_bit_end = (cnt_q == '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_st_idle;
            fifo_rd_q <= 1'b0;
            txd_q     <= 1'b1;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            fifo_rd_q <= fifo_rd_d;
            txd_q     <= txd_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic. txd is registered, so each bit boundary
    // loads the value of the following bit into txd_d together with the
    // bit-period reload; the counter never free-runs across bits.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        fifo_rd_d = 1'b0;
        txd_d     = txd_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;

        case (state_q)
            c_st_idle: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    state_d   = c_st_req;
                    fifo_rd_d = 1'b1;
                end
            end

            // Read strobe is high during this cycle; the FIFO takes it at
            // the edge leaving REQ.
            c_st_req: begin
                state_d = c_st_wait;
            end

            // FIFO data is valid now; capture it and start the frame.
            c_st_wait: begin
                shreg_d  = fifo_op;
                parity_d = ^fifo_op;
                cnt_d    = c_bit_last;
                idx_d    = '0;
                txd_d    = 1'b0;
                state_d  = c_st_start;
            end

            c_st_start: begin
                if (w_bit_end) begin
                    cnt_d   = c_bit_last;
                    txd_d   = shreg_q[0];
                    state_d = c_st_data;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            c_st_data: begin
                if (w_bit_end) begin
                    cnt_d   = c_bit_last;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == c_idx_last) begin
                        if (PARITY_EN != 0) begin
                            txd_d   = parity_q;
                            state_d = c_st_parity;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = c_st_stop;
                        end
                    end else begin
                        idx_d = idx_q + c_idx_one;
                        txd_d = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            c_st_parity: begin
                if (w_bit_end) begin
                    cnt_d   = c_bit_last;
                    txd_d   = 1'b1;
                    state_d = c_st_stop;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            c_st_stop: begin
                if (w_bit_end) begin
                    txd_d   = 1'b1;
                    state_d = c_st_idle;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. busy and tx_done decode the (asynchronously reset) state, so
    // both drop immediately when rst is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != c_st_idle);
        tx_done = (state_q == c_st_stop) && w_bit_end;
    end

    assign fifo_rd = fifo_rd_q;
    assign txd     = txd_q;

endmodule
`default_nettype wire
